// File: rtl/pio_gpio_irq.sv
// pio_gpio_irq: Avalon-MM slave with debounced inputs, per-bit edge capture,
// a maskable level interrupt, and an output register with atomic set/clear.
//
// Ports:
//   clk_clk             system clock; every state change happens on its rising edge
//   reset_reset         synchronous, active-high reset
//   avs_address[2:0]    word address: 0 DATA_IN, 1 DATA_OUT, 2 IRQ_MASK, 3 EDGE_CAP,
//                       4 OUT_SET, 5 OUT_CLR, 6-7 reserved
//   avs_read/avs_write  transfer strobes (no waitrequest; every transfer is accepted)
//   avs_writedata[31:0] write data
//   avs_readdata[31:0]  read data, valid the clock after avs_read, held until the next read
//   pushbuttons_export  raw asynchronous inputs (IN_WIDTH bits)
//   leds_export         output register contents (OUT_WIDTH bits)
//   irq                 level interrupt = OR(edge_capture & irq_mask), registered
module pio_gpio_irq #(
    parameter int unsigned          IN_WIDTH        = 4,
    parameter int unsigned          OUT_WIDTH       = 10,
    parameter int unsigned          DEBOUNCE_CYCLES = 50000,
    parameter int unsigned          EDGE_MODE       = 0,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  pushbuttons_export,
    output logic [OUT_WIDTH-1:0] leds_export,
    output logic                 irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

    logic [IN_WIDTH-1:0]  sync1_q, sync1_d;
    logic [IN_WIDTH-1:0]  sync2_q, sync2_d;
    logic [IN_WIDTH-1:0]  deb_q, deb_d;
    logic [IN_WIDTH-1:0]  deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
    logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                 irq_q, irq_d;
    logic [31:0]          readdata_q, readdata_d;

    logic [IN_WIDTH-1:0]  edge_event;
    logic [IN_WIDTH-1:0]  w1c;
    logic [IN_WIDTH-1:0]  wdata_in;
    logic [OUT_WIDTH-1:0] wdata_out;
    logic                 unused_wdata;

    // Bits of avs_writedata above the register widths are intentionally ignored.
    assign unused_wdata = &{1'b0, avs_writedata};
    assign wdata_in     = avs_writedata[IN_WIDTH-1:0];
    assign wdata_out    = avs_writedata[OUT_WIDTH-1:0];

    // Synchroniser and debounce: the counter measures how long the synchronised
    // bit has continuously disagreed with the debounced bit; any agreement restarts it.
    always_comb begin
        sync1_d    = pushbuttons_export;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < IN_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge selection on the debounced value (one clock after it changes).
    always_comb begin
        case (EDGE_MODE)
            0:       edge_event = deb_q & ~deb_prev_q;
            1:       edge_event = ~deb_q & deb_prev_q;
            default: edge_event = deb_q ^ deb_prev_q;
        endcase
    end

    // Register writes, edge capture, interrupt and read path.
    always_comb begin
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        w1c        = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: data_out_d = wdata_out;
                ADDR_IRQ_MASK: irq_mask_d = wdata_in;
                ADDR_EDGE_CAP: w1c        = wdata_in;
                ADDR_OUT_SET:  data_out_d = data_out_q | wdata_out;
                ADDR_OUT_CLR:  data_out_d = data_out_q & ~wdata_out;
                default:       ;
            endcase
        end

        // A new edge wins over a same-cycle write-1-to-clear.
        edge_cap_d = (edge_cap_q & ~w1c) | edge_event;
        irq_d      = |(edge_cap_q & irq_mask_q);

        // Reads see the register contents before any same-cycle write.
        readdata_d = readdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA_IN:  readdata_d = 32'(deb_q);
                ADDR_DATA_OUT: readdata_d = 32'(data_out_q);
                ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
                ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
                default:       readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            data_out_q <= OUT_RESET;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign leds_export  = data_out_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Testbench for pio_gpio_irq: two instances (rising-edge and both-edge capture)
// share one stimulus stream and are checked every clock against a behavioural model.
module tb_pio_gpio_irq;

    localparam int IW = 4;
    localparam int OW = 10;
    localparam int D  = 4;
    localparam logic [OW-1:0] ORST = 10'h2A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [2:0]    addr;
    logic          rd, wr;
    logic [31:0]   wdata;
    logic [IW-1:0] pins;

    logic [31:0]   rdata0, rdata2;
    logic [OW-1:0] leds0, leds2;
    logic          irq0, irq2;

    pio_gpio_irq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(D),
                   .EDGE_MODE(0), .OUT_RESET(ORST)) dut0 (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd),
        .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata0),
        .pushbuttons_export(pins), .leds_export(leds0), .irq(irq0));

    pio_gpio_irq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(D),
                   .EDGE_MODE(2), .OUT_RESET(ORST)) dut2 (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd),
        .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata2),
        .pushbuttons_export(pins), .leds_export(leds2), .irq(irq2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pins pass through a two-sample delay; the debounced bit flips once the last
    // D delayed samples all disagree with it. Index 0 = rise-only, 1 = both edges.
    logic          m_valid = 1'b0;
    logic [IW-1:0] m_p1, m_p2;
    logic [IW-1:0] m_win [D];
    logic [IW-1:0] m_deb, m_deb_prev, m_mask;
    logic [OW-1:0] m_out;
    logic [IW-1:0] m_cap [2];
    logic          m_irq [2];
    logic [31:0]   m_rd  [2];

    function automatic logic [31:0] regval(input int m, input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_deb);
            3'd1:    return 32'(m_out);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_cap[m]);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [IW-1:0] all_diff, rise, fall, ev, w1c;
        if (rst) begin
            m_valid    = 1'b1;
            m_p1       = '0;
            m_p2       = '0;
            for (int k = 0; k < D; k++) m_win[k] = '0;
            m_deb      = '0;
            m_deb_prev = '0;
            m_mask     = '0;
            m_out      = ORST;
            for (int m = 0; m < 2; m++) begin
                m_cap[m] = '0;
                m_irq[m] = 1'b0;
                m_rd[m]  = '0;
            end
        end else if (m_valid) begin
            for (int k = D - 1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = m_p2;
            all_diff = '1;
            for (int k = 0; k < D; k++) all_diff = all_diff & (m_win[k] ^ m_deb);
            rise = m_deb & ~m_deb_prev;
            fall = ~m_deb & m_deb_prev;
            w1c  = (wr && addr == 3'd3) ? wdata[IW-1:0] : '0;
            for (int m = 0; m < 2; m++) begin
                if (rd) m_rd[m] = regval(m, addr);
                m_irq[m] = |(m_cap[m] & m_mask);
                ev = (m == 0) ? rise : (rise | fall);
                m_cap[m] = (m_cap[m] & ~w1c) | ev;
            end
            if (wr) begin
                case (addr)
                    3'd1: m_out  = wdata[OW-1:0];
                    3'd2: m_mask = wdata[IW-1:0];
                    3'd4: m_out  = m_out | wdata[OW-1:0];
                    3'd5: m_out  = m_out & ~wdata[OW-1:0];
                    default: ;
                endcase
            end
            m_deb_prev = m_deb;
            m_deb      = m_deb ^ all_diff;
            m_p2       = m_p1;
            m_p1       = pins;
        end
        #1;
        if (m_valid) begin
            check("dut0.readdata", rdata0, m_rd[0]);
            check("dut2.readdata", rdata2, m_rd[1]);
            check("dut0.leds", 32'(leds0), 32'(m_out));
            check("dut2.leds", 32'(leds2), 32'(m_out));
            check("dut0.irq", 32'(irq0), 32'(m_irq[0]));
            check("dut2.irq", 32'(irq2), 32'(m_irq[1]));
        end
    end

    // ---------------- directed stimulus + literal expectations ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d0, output logic [31:0] d2);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d0 = rdata0; d2 = rdata2;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    initial begin
        logic [31:0] d0, d2;
        int b;
        rst = 1'b1; pins = '0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

        // Reset held for three clocks.
        tick(3);
        check("rst_leds", 32'(leds0), 32'h2A5);
        check("rst_irq", 32'(irq0), 32'h0);
        rst = 1'b0;
        bus_read(3'd0, d0, d2); check("rst_data_in", d0, 32'h0);
        bus_read(3'd2, d0, d2); check("rst_irq_mask", d0, 32'h0);
        bus_read(3'd3, d0, d2); check("rst_edge_cap", d0, 32'h0);

        // Debounce bit0: capture lands on edge 7, visible in a read one clock later.
        pins[0] = 1'b1; rd = 1'b1; addr = 3'd3;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) check("cap_not_before_d3", rdata0, 32'h0);
            if (k == 8) check("cap_at_d3", rdata0, 32'h1);
        end
        rd = 1'b0;
        tick(2);
        bus_read(3'd0, d0, d2); check("data_in_bit0", d0, 32'h1);

        // Three-clock glitch on bit1 must be rejected.
        pins[1] = 1'b1; tick(3); pins[1] = 1'b0; tick(10);
        bus_read(3'd0, d0, d2); check("glitch_data_in", d0, 32'h1);
        bus_read(3'd3, d0, d2); check("glitch_edge_cap", d0, 32'h1);

        // Interrupt on a masked-in edge.
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, d0, d2); check("w1c_clears", d0, 32'h0);
        bus_write(3'd2, 32'h1);
        pins[0] = 1'b0; tick(10);
        pins[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) check("irq_low_at_capture", 32'(irq0), 32'h0);
            if (k == 8) check("irq_high_after_capture", 32'(irq0), 32'h1);
        end
        wr = 1'b1; addr = 3'd3; wdata = 32'h1;
        @(negedge clk);
        wr = 1'b0;
        check("irq_hold_on_w1c_clock", 32'(irq0), 32'h1);
        @(negedge clk);
        check("irq_drop_after_w1c", 32'(irq0), 32'h0);
        bus_read(3'd3, d0, d2); check("edge_cap_after_w1c", d0, 32'h0);
        pins[2] = 1'b1; tick(10);
        bus_read(3'd3, d0, d2); check("masked_edge_cap", d0, 32'h4);
        check("masked_irq_low", 32'(irq0), 32'h0);

        // Output set / clear.
        bus_write(3'd1, 32'h00F);
        bus_write(3'd4, 32'h300);
        bus_write(3'd5, 32'h003);
        check("leds_set_clr", 32'(leds0), 32'h30C);
        bus_read(3'd1, d0, d2); check("data_out_readback", d0, 32'h30C);

        // Capture beats a same-clock write-1-to-clear.
        bus_write(3'd3, 32'h4);
        pins[0] = 1'b0; tick(10);
        pins[0] = 1'b1; tick(6);
        wr = 1'b1; addr = 3'd3; wdata = 32'h1;
        @(negedge clk);
        wr = 1'b0;
        bus_read(3'd3, d0, d2);
        check("collision_dut0", d0, 32'h1);
        check("collision_dut2", d2, 32'h1);

        // Both-edge mode: press and release each captured and cleared independently.
        bus_write(3'd3, 32'hF);
        pins[3] = 1'b1; tick(10);
        bus_read(3'd3, d0, d2); check("both_press", d2, 32'h8); check("rise_press", d0, 32'h8);
        bus_write(3'd3, 32'h8);
        bus_read(3'd3, d0, d2); check("both_press_cleared", d2, 32'h0);
        pins[3] = 1'b0; tick(10);
        bus_read(3'd3, d0, d2); check("both_release", d2, 32'h8); check("rise_release", d0, 32'h0);
        bus_write(3'd3, 32'h8);
        bus_read(3'd3, d0, d2); check("both_release_cleared", d2, 32'h0);

        // Reset in the middle of a debounce run.
        pins = '0; tick(10);
        pins[1] = 1'b1; tick(4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_irq", 32'(irq0), 32'h0);
        check("midrst_leds", 32'(leds0), 32'h2A5);
        rst = 1'b0; rd = 1'b1; addr = 3'd0;
        for (int k = 6; k <= 12; k++) begin
            @(negedge clk);
            if (k == 6)  check("midrst_data_in", rdata0, 32'h0);
            if (k == 11) check("midrst_not_yet", rdata0, 32'h0);
            if (k == 12) check("midrst_debounced", rdata0, 32'h2);
        end
        rd = 1'b0;
        bus_read(3'd3, d0, d2); check("midrst_capture", d0, 32'h2);

        // Randomised traffic: pin flips, reads, writes, overlaps and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, IW - 1);
                pins[b] = ~pins[b];
            end
            rd    = ($urandom_range(0, 2) == 0);
            wr    = ($urandom_range(0, 3) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = $urandom;
            @(negedge clk);
        end
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
